// File: rtl/filter_pass_sequencer.sv
// Frame sequencer for the pixel filter: image load, per-op 3x3 window scan, write-back.
// Optional STALL_CNT_EN adds a saturating count of stalled window cycles.
module filter_pass_sequencer #(
    parameter int unsigned IMG_DIM     = 21,
    parameter int unsigned PIX_PER_CYC = 3,
    parameter int unsigned LD_W        = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            mode,
    output logic            load_en,
    output logic [LD_W-1:0] load_addr,
    output logic [2:0]      op,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [4:0]      win_row,
    output logic [4:0]      win_col,
    input  logic            fu_idle,
    output logic            wb_req,
    input  logic            wb_ack,
`ifdef STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic            frame_done
);

    localparam int unsigned LoadSlots = (IMG_DIM * IMG_DIM + PIX_PER_CYC - 1) / PIX_PER_CYC;
    localparam logic [LD_W-1:0] LoadLast = LD_W'(LoadSlots - 1);
    localparam logic [4:0] CoordFirst = 5'd2;
    localparam logic [4:0] CoordLast  = 5'(IMG_DIM - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StSetOp, StScan, StDrain, StWb, StDone
    } state_e;

    state_e          state_q;
    logic            mode_q;
    logic [2:0]      step_q;
    logic [2:0]      op_q;
    logic [2:0]      next_op;
    logic            last_op;
    logic            load_en_q;
    logic [LD_W-1:0] load_addr_q;
    logic            win_valid_q;
    logic [4:0]      row_q;
    logic [4:0]      col_q;
    logic            wb_req_q;
    logic            frame_done_q;
`ifdef STALL_CNT_EN
    logic [15:0]     stall_cnt_q;
`endif

    // COLOR chain replaces the third op (SOBEL) with QUANTIZE and stops there.
    always_comb begin
        next_op = step_q;
        if (mode_q && step_q == 3'd2) begin
            next_op = 3'd5;
        end
        last_op = mode_q ? (op_q == 3'd5) : (op_q == 3'd4);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            mode_q       <= 1'b0;
            step_q       <= 3'd0;
            op_q         <= 3'd0;
            load_en_q    <= 1'b0;
            load_addr_q  <= '0;
            win_valid_q  <= 1'b0;
            row_q        <= CoordFirst;
            col_q        <= CoordFirst;
            wb_req_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mode_q      <= mode;
                        step_q      <= 3'd0;
                        load_en_q   <= 1'b1;
                        load_addr_q <= '0;
                        state_q     <= StLoad;
                    end
                end
                StLoad: begin
                    if (load_addr_q == LoadLast) begin
                        load_en_q   <= 1'b0;
                        load_addr_q <= '0;
                        state_q     <= StSetOp;
                    end else begin
                        load_addr_q <= load_addr_q + 1'b1;
                    end
                end
                StSetOp: begin
                    op_q        <= next_op;
                    step_q      <= step_q + 3'd1;
                    row_q       <= CoordFirst;
                    col_q       <= CoordFirst;
                    win_valid_q <= 1'b1;
                    state_q     <= StScan;
                end
                StScan: begin
                    if (win_ready) begin
                        if (row_q == CoordLast && col_q == CoordLast) begin
                            win_valid_q <= 1'b0;
                            state_q     <= StDrain;
                        end else if (col_q == CoordLast) begin
                            col_q <= CoordFirst;
                            row_q <= row_q + 5'd1;
                        end else begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                end
                StDrain: begin
                    if (fu_idle) begin
                        if (last_op) begin
                            frame_done_q <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            wb_req_q <= 1'b1;
                            state_q  <= StWb;
                        end
                    end
                end
                StWb: begin
                    if (wb_ack) begin
                        wb_req_q <= 1'b0;
                        state_q  <= StSetOp;
                    end
                end
                StDone: begin
                    frame_done_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else if (state_q == StIdle && start) begin
            stall_cnt_q <= 16'd0;
        end else if (win_valid_q && !win_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign load_en    = load_en_q;
    assign load_addr  = load_addr_q;
    assign op         = op_q;
    assign win_valid  = win_valid_q;
    assign win_row    = row_q;
    assign win_col    = col_q;
    assign wb_req     = wb_req_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_filter_pass_sequencer.sv
// Directed bench for filter_pass_sequencer: full EDGE/COLOR frames, random ready, abort, DRAIN wait.
// Build with STALL_CNT_EN defined to also check the stall counter.
module tb_filter_pass_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, mode, win_ready, fu_idle, wb_ack;
    logic       load_en, win_valid, wb_req, frame_done;
    logic [7:0] load_addr;
    logic [2:0] op;
    logic [4:0] win_row, win_col;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    filter_pass_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .op         (op),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_row    (win_row),
        .win_col    (win_col),
        .fu_idle    (fu_idle),
        .wb_req     (wb_req),
        .wb_ack     (wb_ack),
`ifdef STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .frame_done (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    int         r_load, r_load_err, r_passes, r_wb, r_done, r_order_err, r_cnt_err;
    int         r_stalls, r_both, r_wb_delay, r_timeout;
    bit         r_aborted;
    logic [2:0] r_ops [8];

    // Runs one frame from a start pulse, observing and driving on negedges.
    task automatic run_frame(input logic m, input bit rnd, input bit t6, input bit abort);
        int         exp_addr = 0;
        int         win_in_pass = 0;
        int         fu_hold = 0;
        int         fu_rise = -1;
        bit         prev_valid = 0;
        bit         prev_wb = 0;
        bit         done = 0;
        logic [4:0] er = 5'd2;
        logic [4:0] ec = 5'd2;
        r_load = 0; r_load_err = 0; r_passes = 0; r_wb = 0; r_done = 0; r_order_err = 0;
        r_cnt_err = 0; r_stalls = 0; r_both = 0; r_wb_delay = -1; r_timeout = 0; r_aborted = 0;
        for (int i = 0; i < 8; i++) r_ops[i] = 3'd7;
        fu_idle = 1'b1; win_ready = 1'b1; wb_ack = 1'b0;
        @(negedge clk);
        mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~m;
        for (int cyc = 0; cyc < 30000 && !done; cyc++) begin
            if (load_en) begin
                if (load_addr != exp_addr[7:0]) r_load_err++;
                exp_addr++;
                r_load++;
            end
            if (load_en && win_valid) r_both++;
            if (win_valid && !prev_valid) begin
                if (r_passes < 8) r_ops[r_passes] = op;
                er = 5'd2; ec = 5'd2; win_in_pass = 0;
            end
            if (!win_valid && prev_valid) begin
                if (win_in_pass != 361) r_cnt_err++;
                r_passes++;
                if (t6 && r_passes == 1) fu_hold = 20;
            end
            if (abort && win_valid && op == 3'd2 && win_row == 5'd10 && win_col == 5'd7) begin
                r_aborted = 1;
                return;
            end
            if (wb_req && !prev_wb) begin
                r_wb++;
                if (fu_rise >= 0) begin
                    r_wb_delay = cyc - fu_rise;
                    fu_rise = -1;
                end
            end
            if (frame_done) r_done++;
            if (fu_hold > 0) begin
                fu_idle = 1'b0;
                fu_hold--;
            end else begin
                if (!fu_idle) fu_rise = cyc;
                fu_idle = 1'b1;
            end
            win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (t6 && r_passes == 0 && win_valid && win_in_pass == 100);
            if (win_valid && win_ready) begin
                if (win_row != er || win_col != ec) r_order_err++;
                win_in_pass++;
                if (ec == 5'd20) begin
                    ec = 5'd2;
                    er = er + 5'd1;
                end else begin
                    ec = ec + 5'd1;
                end
            end
            if (win_valid && !win_ready) r_stalls++;
            wb_ack = wb_req && prev_wb;
            prev_valid = win_valid;
            prev_wb = wb_req;
            if (frame_done) done = 1;
            @(negedge clk);
        end
        r_timeout = done ? 0 : 1;
        for (int k = 0; k < 3; k++) begin
            if (frame_done) r_done++;
            @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_load_en"}, load_en, 0);
        check({tag, "_win_valid"}, win_valid, 0);
        check({tag, "_wb_req"}, wb_req, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_op"}, op, 0);
        check({tag, "_row"}, win_row, 2);
        check({tag, "_col"}, win_col, 2);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        win_ready = 1'b0; fu_idle = 1'b1; wb_ack = 1'b0;

        // T1: reset
        repeat (2) @(negedge clk);
        check_idle_outputs("t1_rst");
        check("t1_load_addr", load_addr, 0);
`ifdef STALL_CNT_EN
        check("t1_stall_cnt", stall_cnt, 0);
`endif
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t1_post");

        // T2: EDGE frame, ready always
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_timeout", r_timeout, 0);
        check("t2_load_cycles", r_load, 147);
        check("t2_load_addr_err", r_load_err, 0);
        check("t2_passes", r_passes, 5);
        check("t2_win_count_err", r_cnt_err, 0);
        check("t2_order_err", r_order_err, 0);
        check("t2_wb_req", r_wb, 4);
        check("t2_frame_done", r_done, 1);
        check("t2_load_and_valid", r_both, 0);
        for (int i = 0; i < 5; i++) check($sformatf("t2_op%0d", i), r_ops[i], i);
        check("t2_no_extra_pass", r_ops[5], 7);

        // T3: COLOR frame
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check("t3_timeout", r_timeout, 0);
        check("t3_passes", r_passes, 3);
        check("t3_op0", r_ops[0], 0);
        check("t3_op1", r_ops[1], 1);
        check("t3_op2", r_ops[2], 5);
        check("t3_no_extra_pass", r_ops[3], 7);
        check("t3_wb_req", r_wb, 2);
        check("t3_frame_done", r_done, 1);

        // T4: random ready
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        check("t4_timeout", r_timeout, 0);
        check("t4_passes", r_passes, 3);
        check("t4_win_count_err", r_cnt_err, 0);
        check("t4_order_err", r_order_err, 0);
        check("t4_frame_done", r_done, 1);
        check("t4_some_stalls", r_stalls > 0, 1);
`ifdef STALL_CNT_EN
        check("t4_stall_cnt", stall_cnt, r_stalls);
`endif

        // T5: reset at window (10,7) of SOBEL
        run_frame(1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_reached_abort", r_aborted, 1);
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("t5_abort");
        reset = 1'b1;
        begin
            int late = 0;
            repeat (5) begin
                @(negedge clk);
                if (frame_done || wb_req || win_valid || load_en) late++;
            end
            check("t5_quiet_after_abort", late, 0);
        end
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        check("t5_restart_timeout", r_timeout, 0);
        check("t5_restart_loads", r_load, 147);
        check("t5_restart_passes", r_passes, 3);
        check("t5_restart_op2", r_ops[2], 5);
        check("t5_restart_done", r_done, 1);

        // T6: start during SCAN, fu_idle low for 20 cycles in first DRAIN
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);
        check("t6_timeout", r_timeout, 0);
        check("t6_loads", r_load, 147);
        check("t6_passes", r_passes, 5);
        check("t6_order_err", r_order_err, 0);
        check("t6_wb_req", r_wb, 4);
        check("t6_wb_delay", r_wb_delay, 1);
        check("t6_frame_done", r_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
